// File: rtl/wrapper_filter_pkg.sv
// wrapper_filter_pkg: shared types for the digest filter slice
package wrapper_filter_pkg;
   typedef enum logic {LAST_ONLY, PASS_ALL} filter_mode_e;
endpackage

// File: rtl/wrapper_count_fifo.sv
// wrapper_count_fifo: DEPTH x W synchronous FIFO holding per-packet digest counts
module wrapper_count_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   lvl_q, lvl_d;
   logic          wr_en, rd_en;

   always_comb begin
      full  = lvl_q == (AW+1)'(DEPTH);
      empty = lvl_q == '0;
      rd_en = pop & ~empty;
      // a pop in the same cycle frees the slot, so a push on full is still taken
      wr_en = push & (~full | rd_en);
      mem_d = mem_q;
      if (wr_en) mem_d[wr_q] = din;
      wr_d  = wr_q + AW'(wr_en);
      rd_d  = rd_q + AW'(rd_en);
      lvl_d = lvl_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      dout  = mem_q[rd_q];
      level = lvl_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         lvl_q <= lvl_d;
      end
   end
endmodule

// File: rtl/wrapper_digest_filter.sv
// wrapper_digest_filter: queues per-packet digest counts from the input handshake
// and forwards only final digest beats (LAST_ONLY) or all beats flagged (PASS_ALL)
module wrapper_digest_filter import wrapper_filter_pkg::*; #(
   parameter int           CNT_W = 16,
   parameter int           DEPTH = 4,
   parameter int           RATIO = 1,
   parameter filter_mode_e MODE  = LAST_ONLY,
   localparam int          LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic          in_ready,
   input  logic          in_last,
   output logic          in_hold,
   input  logic          dig_valid,
   output logic          dig_ready,
   output logic          payload_valid,
   input  logic          payload_ready,
   output logic          payload_last,
   output logic [LW-1:0] pending,
   output logic          err_overflow
);
   logic [CNT_W-1:0]    beats_q, beats_d, dig_cnt_q, dig_cnt_d, head, push_cnt;
   logic [CNT_W:0]      bp1;
   logic [CNT_W+31:0]   prod;
   logic                err_q, err_d;
   logic                accept, push, pop, full, empty, cnt_sat, final_beat;

   wrapper_count_fifo #(.DEPTH(DEPTH), .W(CNT_W)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(push_cnt),
      .dout(head), .full(full), .empty(empty), .level(pending)
   );

   always_comb begin
      accept        = in_valid & in_ready;
      push          = accept & in_last;
      bp1           = {1'b0, beats_q} + (CNT_W+1)'(1);
      prod          = (CNT_W+32)'(bp1) * (CNT_W+32)'(RATIO);
      cnt_sat       = |prod[CNT_W+31:CNT_W];
      push_cnt      = cnt_sat ? '1 : prod[CNT_W-1:0];
      final_beat    = ~empty & (dig_cnt_q == head - CNT_W'(1));
      payload_valid = (MODE == PASS_ALL) ? ~empty & dig_valid : final_beat & dig_valid;
      // LAST_ONLY swallows non-final beats without waiting on the consumer
      dig_ready     = (MODE == PASS_ALL) ? ~empty & payload_ready
                                         : (final_beat ? payload_ready : ~empty);
      payload_last  = final_beat & payload_valid;
      pop           = dig_valid & dig_ready & final_beat;
      dig_cnt_d     = pop ? '0 : (dig_valid & dig_ready) ? dig_cnt_q + CNT_W'(1) : dig_cnt_q;
      beats_d       = push ? '0 : accept ? ((&beats_q) ? beats_q : beats_q + CNT_W'(1)) : beats_q;
      err_d         = err_q | (push & full & ~pop) | (push & cnt_sat)
                    | (accept & ~in_last & (&beats_q));
      in_hold       = full;
      err_overflow  = err_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beats_q   <= '0;
         dig_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         beats_q   <= beats_d;
         dig_cnt_q <= dig_cnt_d;
         err_q     <= err_d;
      end
   end
endmodule

// File: doc/wrapper_digest_filter.md
# wrapper_digest_filter

Parametrised inline filter between a hash/accelerator core's digest output and the wrapper's payload output port. It monitors the accepted input handshake, and records the beat count of each input packet into a small count queue, so several packets can be in flight. It then forwards only the digest beats that belong to a packet's final result, or all beats with a last marker, using a full valid/ready handshake instead of edge detection.

## Interface
Parameters:
- CNT_W, 16: width of beat and digest counters.
- DEPTH, 4: number of packet counts held pending (power of two, ≥2).
- RATIO, 1: digest beats produced per accepted input beat (≥1).
- MODE, LAST_ONLY: filter_mode_e; LAST_ONLY forwards only the final digest beat of each packet, PASS_ALL forwards every beat and flags the final one.

Ports:
- clk  in  1  clock; one clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  input beat valid (monitor only).
- in_ready  in  1  input beat ready as seen by the source (already gated by in_hold at top level).
- in_last  in  1  final beat of input packet.
- in_hold  out  1  count queue full; integrator ANDs ~in_hold into in_ready.
- dig_valid  in  1  digest beat valid from core.
- dig_ready  out  1  digest beat accepted or dropped.
- payload_valid  out  1  forwarded digest beat valid.
- payload_ready  in  1  consumer ready.
- payload_last  out  1  forwarded beat is final digest of its packet.
- pending  out  $clog2(DEPTH)+1  packets counted but not yet finished.
- err_overflow  out  1  sticky: packet end accepted while queue full, or beat counter saturated.

## Operation
- Input accept = in_valid & in_ready. Beat counter increments per accept; on accept with in_last, push (beats+1)*RATIO into the queue and clear the counter.
- Expected count is computed in CNT_W bits; if the beat counter or the product exceeds 2^CNT_W-1, saturate it and set err_overflow.
- A push while full with no pop in the same cycle drops the count and sets err_overflow. A push and pop in the same cycle while full is legal.
- Queue empty: dig_ready=0, payload_valid=0. Digests stall until a count is known.
- Queue non-empty: final = (dig_count == head-1).
  - LAST_ONLY: for a non-final beat, dig_ready=1 and payload_valid=0 (dropped). For a final beat, payload_valid=dig_valid and dig_ready=payload_ready.
  - PASS_ALL: payload_valid=dig_valid, dig_ready=payload_ready.
  - payload_last=final & payload_valid.
- Each digest accept (dig_valid & dig_ready) increments dig_count. A final accept clears dig_count and pops the head.
- in_hold = queue full. pending = queue occupancy.
- err_overflow clears only on reset.

## Timing
- Reset values: dig_ready 0, payload_valid 0, payload_last 0, in_hold 0, pending 0, err_overflow 0. All counters and the queue are empty.
- Output path is combinational from dig_valid/payload_ready to the registered head and dig_count; there is no added latency on the digest path.
- Push-to-use latency is 1 cycle: a count pushed at edge N can match digests presented in cycle N+1 onward.
- A stalled payload (payload_valid=1, payload_ready=0) holds the beat. dig_count is unchanged.
- Reset asserted mid-packet clears everything asynchronously. Partial packets are discarded.

## Structure
- wrapper_filter_pkg: filter_mode_e {LAST_ONLY, PASS_ALL}.
- Sub-module wrapper_count_fifo: synchronous FIFO, DEPTH×CNT_W, with push/pop/full/empty/level outputs. The simultaneous push+pop-when-full case is handled inside it.

## Test plan
- LAST_ONLY, RATIO=1: 3-beat packet, then 3 digests with payload_ready=1 → beats 1–2 dropped with dig_ready=1; payload_valid only on beat 3, payload_last=1; pending returns 0.
- Packets of 2 and 4 beats, both pushed before any digest, then 6 digests → forwarded on digest 2 and digest 6 only; pending goes 2→1→0.
- DEPTH=4: 4 packets pending → in_hold=1; force a 5th last-accept → err_overflow=1 and pending stays 4. Next, a last-accept coinciding with a final-digest pop keeps pending=4 and raises no new error.
- Digest presented while queue empty → dig_ready=0. Count pushed at edge N → beat matched from cycle N+1.
- PASS_ALL, RATIO=2, 2-beat packet, payload_ready low 3 cycles on beat 2 → dig_ready=0 while low, then 4 beats forwarded, payload_last on beat 4.
- rst_n low for 1 cycle mid-packet (2 beats counted) → all outputs reset. A new 1-beat packet then needs exactly 1 digest.
